// File: rtl/registra_tiro_if.sv
// registra_tiro_if
// Memory-side bus between the shot writer and the two per-player ship memories.
//   mem_addr     entry address (0..N_NAVIOS-1)
//   mem_wdata    write data, valid while mem_we is high
//   mem_we       one-cycle write strobe
//   jogador_out  selects which player's memory is accessed
//   mem_rdata    registered read data, valid one cycle after mem_addr
// master: the shot writer; slave: the memory (or its model).
interface registra_tiro_if;
   logic [4:0]  mem_addr;
   logic [63:0] mem_wdata;
   logic        mem_we;
   logic        jogador_out;
   logic [63:0] mem_rdata;

   modport master (
      output mem_addr,
      output mem_wdata,
      output mem_we,
      output jogador_out,
      input  mem_rdata
   );

   modport slave (
      input  mem_addr,
      input  mem_wdata,
      input  mem_we,
      input  jogador_out,
      output mem_rdata
   );
endinterface

// File: rtl/registra_tiro.sv
// registra_tiro
// Applies one shot to the opponent's ship memory: scans the ship entries in
// address order, clears every cell slot equal to {linha, coluna} in the first
// matching entry (read-modify-write) and reports hit / sunk / miss / invalid.
// Ports:
//   clk, reset           clock; synchronous active-low reset
//   start                one-cycle request, only looked at while idle
//   jogador_in           shooting player (0 = P1, 1 = P2)
//   linha, coluna        target cell, legal 1..MAX_COORD
//   mem                  memory bus (registra_tiro_if.master)
//   busy, done           scan in progress / one-cycle completion pulse
//   acerto, afundou      hit / hit that emptied the ship
//   invalido             coordinate out of range, no memory access made
//   navio_addr           entry that was hit
//   tiros_p1, tiros_p2   valid-shot counters, saturating at 100
// Optional feature: define TIRO_ESTATISTICA_EN to build the shot counters;
// without it both counters read as zero.
module registra_tiro #(
   parameter int N_NAVIOS  = 11,
   parameter int MAX_COORD = 10
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 jogador_in,
   input  logic [3:0]           linha,
   input  logic [3:0]           coluna,
   registra_tiro_if.master      mem,
   output logic                 busy,
   output logic                 done,
   output logic                 acerto,
   output logic                 afundou,
   output logic                 invalido,
   output logic [4:0]           navio_addr,
   output logic [6:0]           tiros_p1,
   output logic [6:0]           tiros_p2
);

   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] ENDERECO = 3'd1;
   localparam logic [2:0] DADO     = 3'd2;
   localparam logic [2:0] ESCRITA  = 3'd3;
   localparam logic [2:0] FIM      = 3'd4;

   localparam logic [4:0] ULTIMO   = 5'(N_NAVIOS - 1);
   localparam logic [3:0] COORD_MAX = 4'(MAX_COORD);

   logic [2:0]  state_r;
   logic [3:0]  linha_r;
   logic [3:0]  coluna_r;
   logic        jog_r;
   logic [4:0]  addr_r;
   logic [63:0] wdata_r;
   logic        we_r;
   logic        busy_r;
   logic        done_r;
   logic        acerto_r;
   logic        afundou_r;
   logic        invalido_r;
   logic [4:0]  navio_r;

   logic [63:0] novo_s;
   logic        casou_s;
   logic        coord_invalida_s;

   // Zero every cell slot in [42:3] that equals the target cell.
   function automatic logic [63:0] limpa_slots(input logic [63:0] dado,
                                               input logic [7:0]  alvo);
      logic [63:0] res;
      res = dado;
      for (int k = 0; k < 5; k++) begin
         res[3 + 8*k +: 8] = (dado[3 + 8*k +: 8] == alvo) ? 8'h00 : dado[3 + 8*k +: 8];
      end
      return res;
   endfunction

   // Slot compare on the current read data and range check of the new request.
   always_comb begin
      novo_s  = limpa_slots(mem.mem_rdata, {linha_r, coluna_r});
      // A legal target is never 8'h00, so any change means at least one slot matched.
      casou_s = (novo_s != mem.mem_rdata);
      coord_invalida_s = (linha == 4'd0) || (linha > COORD_MAX) ||
                         (coluna == 4'd0) || (coluna > COORD_MAX);
   end

   // Scan FSM with all registered outputs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r    <= IDLE;
         linha_r    <= 4'd0;
         coluna_r   <= 4'd0;
         jog_r      <= 1'b0;
         addr_r     <= 5'd0;
         wdata_r    <= 64'd0;
         we_r       <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         acerto_r   <= 1'b0;
         afundou_r  <= 1'b0;
         invalido_r <= 1'b0;
         navio_r    <= 5'd0;
      end else begin
         case (state_r)
            IDLE: begin
               done_r <= 1'b0;
               // The done cycle of a miss/invalid shot is spent here; start waits one more cycle.
               if (start && !done_r) begin
                  linha_r   <= linha;
                  coluna_r  <= coluna;
                  jog_r     <= !jogador_in;
                  acerto_r  <= 1'b0;
                  afundou_r <= 1'b0;
                  navio_r   <= 5'd0;
                  busy_r    <= 1'b1;
                  if (coord_invalida_s) begin
                     invalido_r <= 1'b1;
                     state_r    <= FIM;
                  end else begin
                     invalido_r <= 1'b0;
                     addr_r     <= 5'd0;
                     state_r    <= ENDERECO;
                  end
               end else begin
                  state_r <= IDLE;
               end
            end
            ENDERECO: begin
               state_r <= DADO;
            end
            DADO: begin
               if (casou_s) begin
                  wdata_r   <= novo_s;
                  we_r      <= 1'b1;
                  acerto_r  <= 1'b1;
                  navio_r   <= addr_r;
                  afundou_r <= (novo_s[42:3] == 40'd0);
                  state_r   <= ESCRITA;
               end else if (addr_r == ULTIMO) begin
                  state_r <= FIM;
               end else begin
                  addr_r  <= addr_r + 5'd1;
                  state_r <= ENDERECO;
               end
            end
            ESCRITA: begin
               // Completion is signalled together with the end of the write strobe.
               we_r    <= 1'b0;
               done_r  <= 1'b1;
               busy_r  <= 1'b0;
               state_r <= FIM;
            end
            FIM: begin
               // Coming from ESCRITA the pulse is already out; otherwise raise it now.
               if (done_r) begin
                  done_r <= 1'b0;
               end else begin
                  done_r <= 1'b1;
                  busy_r <= 1'b0;
               end
               state_r <= IDLE;
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign mem.mem_addr    = addr_r;
   assign mem.mem_wdata   = wdata_r;
   assign mem.mem_we      = we_r;
   assign mem.jogador_out = jog_r;
   assign busy            = busy_r;
   assign done            = done_r;
   assign acerto          = acerto_r;
   assign afundou         = afundou_r;
   assign invalido        = invalido_r;
   assign navio_addr      = navio_r;

`ifdef TIRO_ESTATISTICA_EN
   logic [6:0] tiros_p1_r;
   logic [6:0] tiros_p2_r;
   logic       conta_s;

   // A valid shot completes on the edge that raises done.
   always_comb begin
      conta_s = ((state_r == ESCRITA) || ((state_r == FIM) && !done_r)) && !invalido_r;
   end

   // Saturating per-player valid-shot counters (jog_r high means P1 fired).
   always_ff @(posedge clk) begin
      if (!reset) begin
         tiros_p1_r <= 7'd0;
         tiros_p2_r <= 7'd0;
      end else if (conta_s) begin
         if (jog_r) begin
            tiros_p1_r <= (tiros_p1_r == 7'd100) ? tiros_p1_r : tiros_p1_r + 7'd1;
         end else begin
            tiros_p2_r <= (tiros_p2_r == 7'd100) ? tiros_p2_r : tiros_p2_r + 7'd1;
         end
      end else begin
         tiros_p1_r <= tiros_p1_r;
         tiros_p2_r <= tiros_p2_r;
      end
   end

   assign tiros_p1 = tiros_p1_r;
   assign tiros_p2 = tiros_p2_r;
`else
   assign tiros_p1 = 7'd0;
   assign tiros_p2 = 7'd0;
`endif

endmodule

// File: tb/tb_registra_tiro.sv
// tb_registra_tiro
// Directed bench for registra_tiro with a registered two-player memory model.
module tb_registra_tiro;
   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       jogador_in;
   logic [3:0] linha;
   logic [3:0] coluna;
   logic       busy, done, acerto, afundou, invalido;
   logic [4:0] navio_addr;
   logic [6:0] tiros_p1, tiros_p2;

   registra_tiro_if bus ();

   registra_tiro dut (
      .clk(clk), .reset(reset), .start(start), .jogador_in(jogador_in),
      .linha(linha), .coluna(coluna), .mem(bus), .busy(busy), .done(done),
      .acerto(acerto), .afundou(afundou), .invalido(invalido),
      .navio_addr(navio_addr), .tiros_p1(tiros_p1), .tiros_p2(tiros_p2)
   );

   always #5 clk = ~clk;

   // memory model: index [player][entry]; loading port plus write logging
   logic [63:0] mem_arr [2][11];
   logic        ld_en = 1'b0;
   logic        ld_j;
   logic [4:0]  ld_a;
   logic [63:0] ld_d;
   int          edge_cnt = 0;
   int          we_cnt = 0;
   int          we_edge = 0;
   logic [4:0]  we_addr = 5'd0;
   logic        we_jog = 1'b0;
   logic [63:0] we_data = 64'd0;

   always @(posedge clk) begin
      edge_cnt <= edge_cnt + 1;
      if (ld_en) mem_arr[ld_j][ld_a] <= ld_d;
      if (bus.mem_we === 1'b1) begin
         mem_arr[bus.jogador_out][bus.mem_addr] <= bus.mem_wdata;
         we_cnt  <= we_cnt + 1;
         we_edge <= edge_cnt + 1;
         we_addr <= bus.mem_addr;
         we_jog  <= bus.jogador_out;
         we_data <= bus.mem_wdata;
      end
      if (bus.mem_addr < 5'd11) bus.mem_rdata <= mem_arr[bus.jogador_out][bus.mem_addr];
      else bus.mem_rdata <= 64'd0;
   end

   int total = 0;
   int bad = 0;
   int last_e0;
   logic busy_e0;

   function automatic logic [63:0] mk(input logic [20:0] hi, input logic [7:0] s4, input logic [7:0] s3,
                                      input logic [7:0] s2, input logic [7:0] s1, input logic [7:0] s0,
                                      input logic [2:0] lo);
      return {hi, s4, s3, s2, s1, s0, lo};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ld(input logic j, input logic [4:0] a, input logic [63:0] d);
      ld_en = 1'b1; ld_j = j; ld_a = a; ld_d = d;
      tick();
      ld_en = 1'b0;
   endtask

   // Fire one shot; lat = edges from E0 to done (-1 if done never came).
   task automatic tiro(input logic j, input logic [3:0] l, input logic [3:0] c, output int lat);
      int e0;
      jogador_in = j; linha = l; coluna = c; start = 1'b1;
      tick();
      e0 = edge_cnt;
      start = 1'b0;
      busy_e0 = busy;
      lat = -1;
      for (int n = 0; n < 40 && lat < 0; n++) begin
         tick();
         if (done === 1'b1) lat = edge_cnt - e0;
      end
      last_e0 = e0;
      tick();
   endtask

   initial begin
      int lat, w0, e0, exp_p1, exp_p2, done_seen;
      reset = 1'b0; start = 1'b0; jogador_in = 1'b0; linha = 4'd0; coluna = 4'd0;
      for (int j = 0; j < 2; j++)
         for (int a = 0; a < 11; a++)
            ld(j[0], a[4:0], mk(21'h000A00 + 21'(a), 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 3'b010));
      ld(1'b1, 5'd0, mk(21'h15A5A5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h35, 3'b101));
      ld(1'b1, 5'd9, mk(21'h0F0F0F, 8'h00, 8'h14, 8'h13, 8'h12, 8'h11, 3'b011));
      ld(1'b0, 5'd4, mk(21'h1C3C3C, 8'h00, 8'h00, 8'h00, 8'h00, 8'hAA, 3'b110));
      tick();

      // reset state
      chk("rst_addr",  {59'd0, bus.mem_addr}, 64'd0);
      chk("rst_wdata", bus.mem_wdata, 64'd0);
      chk("rst_flags", {56'd0, bus.mem_we, bus.jogador_out, busy, done, acerto, afundou, invalido, 1'b0}, 64'd0);
      chk("rst_navio", {59'd0, navio_addr}, 64'd0);
      chk("rst_tiros", {50'd0, tiros_p1, tiros_p2}, 64'd0);
      reset = 1'b1;
      tick();
      exp_p1 = 0; exp_p2 = 0;

      // hit that sinks: P1 fires (3,5) at entry 0 of P2's memory
      tiro(1'b0, 4'd3, 4'd5, lat); exp_p1++;
      chk("sink_lat", 64'(lat), 64'd3);
      chk("sink_busy_e0", {63'd0, busy_e0}, 64'd1);
      chk("sink_we_cnt", 64'(we_cnt), 64'd1);
      chk("sink_we_edge", 64'(we_edge - last_e0), 64'd3);
      chk("sink_we_where", {58'd0, we_jog, we_addr}, {58'd0, 1'b1, 5'd0});
      chk("sink_wdata", we_data, mk(21'h15A5A5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 3'b101));
      chk("sink_flags", {57'd0, acerto, afundou, invalido, navio_addr}, {57'd0, 1'b1, 1'b1, 1'b0, 5'd0});
      chk("sink_busy_after", {62'd0, busy, done}, 64'd0);

      // partial hit at entry 9: slot2 (1,3) cleared
      tiro(1'b0, 4'd1, 4'd3, lat); exp_p1++;
      chk("part_lat", 64'(lat), 64'd21);
      chk("part_we_edge", 64'(we_edge - last_e0), 64'd21);
      chk("part_wdata", we_data, mk(21'h0F0F0F, 8'h00, 8'h14, 8'h00, 8'h12, 8'h11, 3'b011));
      chk("part_flags", {57'd0, acerto, afundou, invalido, navio_addr}, {57'd0, 1'b1, 1'b0, 1'b0, 5'd9});
      chk("part_addr", {58'd0, we_jog, we_addr}, {58'd0, 1'b1, 5'd9});

      // invalid coordinates: no address change, no write, flags cleared
      w0 = we_cnt;
      tiro(1'b0, 4'd0, 4'd3, lat);
      chk("inv0_lat", 64'(lat), 64'd1);
      chk("inv0_flags", {57'd0, acerto, afundou, invalido, navio_addr}, {57'd0, 1'b0, 1'b0, 1'b1, 5'd0});
      chk("inv0_addr", {59'd0, bus.mem_addr}, 64'd9);
      tiro(1'b0, 4'd11, 4'd3, lat);
      chk("inv11_lat", 64'(lat), 64'd1);
      chk("inv11_flag", {63'd0, invalido}, 64'd1);
      tiro(1'b1, 4'd2, 4'd15, lat);
      chk("invcol_lat", 64'(lat), 64'd1);
      chk("inv_no_write", 64'(we_cnt), 64'(w0));

      // miss (7,7): full scan, last address 10, no write
      tiro(1'b0, 4'd7, 4'd7, lat); exp_p1++;
      chk("miss_lat", 64'(lat), 64'd23);
      chk("miss_flags", {60'd0, acerto, afundou, invalido, 1'b0}, 64'd0);
      chk("miss_addr", {59'd0, bus.mem_addr}, 64'd10);
      chk("miss_no_write", 64'(we_cnt), 64'(w0));

      // repeat shot (3,5): the cleared slot cannot match again
      tiro(1'b0, 4'd3, 4'd5, lat); exp_p1++;
      chk("rep_lat", 64'(lat), 64'd23);
      chk("rep_acerto", {63'd0, acerto}, 64'd0);
      chk("rep_no_write", 64'(we_cnt), 64'(w0));

      // P2 fires at P1's memory, corner cell (10,10) at entry 4
      tiro(1'b1, 4'd10, 4'd10, lat); exp_p2++;
      chk("p2_lat", 64'(lat), 64'd11);
      chk("p2_where", {58'd0, we_jog, we_addr}, {58'd0, 1'b0, 5'd4});
      chk("p2_wdata", we_data, mk(21'h1C3C3C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 3'b110));
      chk("p2_flags", {57'd0, acerto, afundou, invalido, navio_addr}, {57'd0, 1'b1, 1'b1, 1'b0, 5'd4});

      // start pulses while busy are ignored: a (1,1) hit must not be taken
      w0 = we_cnt;
      jogador_in = 1'b0; linha = 4'd7; coluna = 4'd7; start = 1'b1;
      tick(); e0 = edge_cnt; start = 1'b0;
      tick(); tick(); tick();
      linha = 4'd1; coluna = 4'd1; start = 1'b1;
      tick(); start = 1'b0;
      lat = -1;
      for (int n = 0; n < 40 && lat < 0; n++) begin
         tick();
         if (done === 1'b1) lat = edge_cnt - e0;
      end
      tick();
      exp_p1++;
      chk("busy_ign_lat", 64'(lat), 64'd23);
      chk("busy_ign_write", 64'(we_cnt), 64'(w0));
`ifdef TIRO_ESTATISTICA_EN
      chk("stat_p1", 64'(tiros_p1), 64'(exp_p1));
      chk("stat_p2", 64'(tiros_p2), 64'(exp_p2));
`else
      chk("stat_off", {50'd0, tiros_p1, tiros_p2}, 64'd0);
`endif

      // reset low at E4 of a scan heading for a hit at entry 9
      jogador_in = 1'b0; linha = 4'd1; coluna = 4'd2; start = 1'b1;
      tick(); start = 1'b0;
      tick(); tick(); tick();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      chk("rst_mid_out", {58'd0, bus.mem_we, bus.jogador_out, busy, done, acerto, invalido}, 64'd0);
      chk("rst_mid_addr", {59'd0, bus.mem_addr}, 64'd0);
      chk("rst_mid_tiros", {50'd0, tiros_p1, tiros_p2}, 64'd0);
      done_seen = 0;
      for (int n = 0; n < 30; n++) begin
         tick();
         if (done === 1'b1 || busy === 1'b1) done_seen++;
      end
      chk("rst_mid_idle", 64'(done_seen), 64'd0);
      chk("rst_mid_write", 64'(we_cnt), 64'(w0));
      exp_p1 = 0; exp_p2 = 0;
      tiro(1'b0, 4'd1, 4'd2, lat); exp_p1++;
      chk("after_rst_lat", 64'(lat), 64'd21);
      chk("after_rst_wdata", we_data, mk(21'h0F0F0F, 8'h00, 8'h14, 8'h00, 8'h00, 8'h11, 3'b011));

`ifdef TIRO_ESTATISTICA_EN
      // 101 valid P2 shots saturate the counter at 100
      for (int n = 0; n < 101; n++) tiro(1'b1, 4'd7, 4'd7, lat);
      chk("sat_p2", 64'(tiros_p2), 64'd100);
      chk("sat_p1", 64'(tiros_p1), 64'(exp_p1));
`else
      chk("stat_off2", {50'd0, tiros_p1, tiros_p2}, 64'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/registra_tiro.md
# registra_tiro

Shot-application writer for the battleship player memory. Given a target cell and the shooting player, it scans the opponent's 11 ship entries, clears the matching cell slot by read-modify-write, and reports hit, sunk and miss. It is the write-side counterpart of the scoring reader, which treats an entry whose field [42:3] is all-zero as a sunk ship. It sits between the game-execution FSM and the two per-player ship memories.

## Interface
Parameters:
- N_NAVIOS, 11: ship entries per player, addresses 0..N_NAVIOS-1.
- MAX_COORD, 10: highest legal row/column value.

Ports:
- clk  in  1  system clock.
- reset  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle request, sampled only in IDLE.
- jogador_in  in  1  shooting player (0 = P1, 1 = P2).
- linha  in  4  target row, legal range 1..MAX_COORD.
- coluna  in  4  target column, legal range 1..MAX_COORD.
- mem_rdata  in  64  read data. Registered memory: valid one cycle after mem_addr.
- mem_addr  out  5  entry address.
- mem_wdata  out  64  write data.
- mem_we  out  1  write strobe, one cycle.
- jogador_out  out  1  memory being accessed. Equals !jogador_in, latched at start.
- busy  out  1  high from the cycle after the accepted start until done.
- done  out  1  one-cycle completion pulse.
- acerto  out  1  hit.
- afundou  out  1  hit that emptied the ship.
- invalido  out  1  coordinate was out of range.
- navio_addr  out  5  address of the entry that was hit.
- tiros_p1, tiros_p2  out  7 each  shot counters (see Configuration).

## Operation
Entry format:
- Five 8-bit cell slots in bits [42:3]. Slot k is bits [10+8k : 3+8k] and holds {row[3:0], col[3:0]}.
- Slot value 8'h00 means an empty or already-hit cell.
- All other bits of the entry are preserved on write.

States:
- IDLE: on start, latch linha, coluna and jogador_out. Clear acerto, afundou, invalido and navio_addr.
  - If linha or coluna is 0 or greater than MAX_COORD: set invalido and go to FIM. No memory access occurs.
  - Otherwise: set idx=0 and mem_addr=0, go to ENDERECO.
- ENDERECO: go to DADO.
- DADO: compare every slot against {linha, coluna}.
  - Any slot matches: wdata = rdata with all matching slots zeroed. Set acerto=1, navio_addr=idx, and afundou = (new [42:3] == 0). Go to ESCRITA.
  - No match, idx == N_NAVIOS-1: go to FIM (miss).
  - No match otherwise: idx+1, mem_addr+1, go to ENDERECO.
- ESCRITA: mem_we=1 with mem_wdata for one cycle, mem_addr unchanged. Go to FIM. The scan stops at the first matching entry.
- FIM: done=1, go to IDLE.

Output persistence: acerto, afundou, invalido and navio_addr hold until the next accepted start.

Boundary cases:
- Repeat shot on an already-hit cell cannot match a zero slot, so it reports a miss with no write.
- start while busy is ignored.
- reset low overrides everything. It returns the block to IDLE with all outputs at their reset values.
- reset mid-scan performs no write. If reset coincides with ESCRITA, the strobe is dropped at that edge.

## Timing
- Reset values: mem_addr 0, mem_wdata 0, mem_we 0, jogador_out 0, busy 0, done 0, acerto 0, afundou 0, invalido 0, navio_addr 0, tiros_p1 0, tiros_p2 0.
- All outputs are registered. Latencies are counted in edges after the edge that samples start (E0):
  - Invalid coordinate: done at E1.
  - Hit at entry k: mem_we during the cycle after E(2k+2), done at E(2k+3).
  - Miss: done at E(2·N_NAVIOS+1), which is E23 at default.
- A new start is accepted in the cycle after done.

## Configuration
- TIRO_ESTATISTICA_EN defined:
  - tiros_p1 counts valid (non-invalido) shots fired by P1; tiros_p2 does the same for P2.
  - Each counter increments at the FIM transition and saturates at 100.
- TIRO_ESTATISTICA_EN undefined: tiros_p1 and tiros_p2 are tied to 0 and the counters are not synthesized.

## Test plan
- Hit that sinks: entry 0 holds only slot0=8'h35, P1 shoots (3,5). Required: mem_we with jogador_out=1 and addr 0, [42:3]=0, other bits unchanged. Flags acerto=1, afundou=1, navio_addr=0. done at E3.
- Partial hit: entry 9 holds slots 8'h11, 8'h12, 8'h13, 8'h14. Shoot (1,3). Required: slot2 cleared, acerto=1, afundou=0, navio_addr=9, done at E21.
- Miss: memory has no (7,7), shoot (7,7). Required: 11 reads, no mem_we, acerto=0, done at E23.
- Invalid coordinates: linha=0 gives invalido=1 at E1 with no address change. linha=11 behaves the same.
- Repeat shot: fire (3,5) twice. Required: first is a hit, second is a miss, and mem_we is asserted exactly once.
- Reset and interference: reset low at E4 of a scan leaves the block in IDLE with no write. start pulses while busy are ignored. With TIRO_ESTATISTICA_EN defined, 101 valid P2 shots leave tiros_p2=100.
